rgb_buf_sequencer: RTL and testbench
====================================

# rgb_buf_sequencer

Control block for the two pixel buffers (Buf1, Buf2) and their R/G/B output multiplexers in the display adaptor. It accepts 24-bit pixels from the frame-fetch side into the buffers in ping-pong order. It then drives one-hot R/G/B selects to step each buffer's mux through its three colour bytes toward the byte-serial display interface, and flags the last byte of every line.

## Interface
Parameters:
- LINE_PIXELS, 640, pixels per display line; must be ≥ 2.
- CW, 10, pixel-counter width; must satisfy 2^CW ≥ LINE_PIXELS.

Ports:
- Clk  input  1  single clock; all state changes on rising edge.
- Rst_n  input  1  reset, synchronous and active-low.
- PixValid  input  1  upstream has a pixel for the buffers.
- PixReady  output  1  a buffer is free; pixel accepted when PixValid & PixReady at an edge.
- Load1  output  1  load strobe for Buf1 registers; equals PixValid & PixReady & (WrPtr==0).
- Load2  output  1  load strobe for Buf2 registers; equals PixValid & PixReady & (WrPtr==1).
- SelR1, SelG1, SelB1  output  1 each  one-hot selects for the Buf1 mux.
- SelR2, SelG2, SelB2  output  1 each  one-hot selects for the Buf2 mux.
- OutSel  output  1  0 = Buf1 mux drives the display byte, 1 = Buf2 mux.
- ByteValid  output  1  the selected byte is valid to the display interface.
- ByteReady  input  1  display interface consumes the byte at this edge.
- EndOfLine  output  1  the current byte is the B byte of pixel LINE_PIXELS-1.

## Operation
- Internal state: Full1, Full2, WrPtr, RdPtr, read FSM {IDLE, SEND_R, SEND_G, SEND_B}, PixCount[CW-1:0].
- Write side:
  - PixReady = Rst_n & ~Full[WrPtr], combinational from registered state.
  - On accept, set Full[WrPtr] and toggle WrPtr.
- Read FSM:
  - IDLE: if Full[RdPtr] → SEND_R.
  - SEND_R: on ByteReady → SEND_G.
  - SEND_G: on ByteReady → SEND_B.
  - SEND_B: on ByteReady:
    - clear Full[RdPtr] and toggle RdPtr;
    - increment PixCount, wrapping LINE_PIXELS-1 → 0;
    - next state is SEND_R if the other buffer is Full, else IDLE.
- Outputs are decoded from registered state, so they are glitch-free:
  - ByteValid = (state ≠ IDLE); OutSel = RdPtr.
  - SelR/G/B of buffer RdPtr follow the state one-hot. Selects of the other buffer, and all selects in IDLE, are 0.
  - Never more than one select of the six is high.
  - EndOfLine = (state==SEND_B) & (PixCount==LINE_PIXELS-1).
- Without ByteReady, state, selects, OutSel and EndOfLine hold. ByteValid is never withdrawn before ByteReady.
- Simultaneous write and read-release:
  - A write never targets a Full buffer, so no set/clear collision on the same buffer is possible.
  - A buffer released at edge E is writable from the cycle after E.
- Rst_n low at any edge:
  - Full1 = Full2 = 0, WrPtr = RdPtr = 0, state = IDLE, PixCount = 0.
  - Any in-flight pixel is dropped.
  - PixReady is forced 0 while Rst_n is low.

## Timing
- Reset values: PixReady 0 (rises in the first cycle with Rst_n high); all other outputs 0.
- Latency: pixel accepted at edge E → SelR/ByteValid high after edge E+1. This is one cycle of FSM entry.
- Throughput with ByteReady held high: 3 cycles per pixel, with no bubble between pixels when the other buffer is full.
- With upstream always valid, both buffers fill. PixReady then drops until the B byte of the older pixel is consumed, and returns high in the following cycle.
- Load1/Load2 are combinational and one cycle wide per accepted pixel. The buffer registers capture on the same edge as the accept.

## Test plan
- Reset: hold Rst_n=0 for 3 cycles with PixValid=1 → PixReady=0, Load1=Load2=0, all selects 0, ByteValid=0; PixReady=1 in the first cycle after release.
- Single pixel, ByteReady=1: accept at edge E → Load1 pulse at E. SelR1 after E+1, SelG1 after E+2, SelB1 after E+3, IDLE after E+4; OutSel=0 throughout; PixReady returns high.
- Streaming, PixValid=1 and ByteReady=1: accepts alternate Load1/Load2. Selects cycle R1,G1,B1,R2,G2,B2 with no bubble; OutSel toggles every 3 cycles; PixReady low only while both buffers are full.
- Backpressure: ByteReady=0 for 5 cycles during SEND_G → SelG1 and ByteValid hold; Full stays set; a second pixel fills Buf2; a third sees PixReady=0.
- Line end, LINE_PIXELS=4: stream 8 pixels → EndOfLine high only during the B bytes of pixels 4 and 8; PixCount wraps to 0.
- Reset mid-operation: assert Rst_n=0 during SEND_B with both buffers full → next cycle all outputs 0 and state IDLE. After release, the first accepted pixel loads Buf1 (Load1) and is read with SelR1.

Source files
------------

// File: rtl/rgb_buf_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_buf_sequencer
//  Function : Ping-pong write control for two 24-bit pixel buffers and a
//             byte-serial R/G/B read sequencer with one-hot mux selects and
//             an end-of-line flag on the last byte of each display line.
//  Revision : 1.0 - initial release
// ============================================================================
module rgb_buf_sequencer #(
    parameter int LINE_PIXELS = 640,
    parameter int CW          = 10
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic PixValid,
    output logic PixReady,
    output logic Load1,
    output logic Load2,
    output logic SelR1,
    output logic SelG1,
    output logic SelB1,
    output logic SelR2,
    output logic SelG2,
    output logic SelB2,
    output logic OutSel,
    output logic ByteValid,
    input  logic ByteReady,
    output logic EndOfLine
);

    localparam logic [CW-1:0] LAST_PIX = CW'(LINE_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_R = 2'd1,
        SEND_G = 2'd2,
        SEND_B = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          full1;
    logic          full2;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [CW-1:0] pix_count;

    logic full_wr;
    logic full_rd;
    logic full_other;
    logic accept;
    logic release_px;

    // Buffer status seen from each pointer, plus the handshake events
    always_comb begin
        full_wr    = wr_ptr ? full2 : full1;
        full_rd    = rd_ptr ? full2 : full1;
        full_other = rd_ptr ? full1 : full2;
        PixReady   = Rst_n & ~full_wr;
        accept     = PixValid & PixReady;
        Load1      = accept & ~wr_ptr;
        Load2      = accept & wr_ptr;
        release_px = (state == SEND_B) & ByteReady;
    end

    // Buffer occupancy flags and ping-pong pointers; writes never hit a full
    // buffer, so the set and clear of one flag can never coincide
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            full1  <= 1'b0;
            full2  <= 1'b0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (release_px) begin
                if (rd_ptr) full2 <= 1'b0;
                else        full1 <= 1'b0;
                rd_ptr <= ~rd_ptr;
            end
            if (accept) begin
                if (wr_ptr) full2 <= 1'b1;
                else        full1 <= 1'b1;
                wr_ptr <= ~wr_ptr;
            end
        end
    end

    // Pixel position within the current line, advanced per completed pixel
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pix_count <= '0;
        end else if (release_px) begin
            if (pix_count == LAST_PIX) pix_count <= '0;
            else                       pix_count <= pix_count + 1'b1;
        end
    end

    // Read sequencer state register
    always_ff @(posedge Clk) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Read sequencer next state: R, G, B per pixel, chaining straight into
    // the other buffer when it is already loaded
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (full_rd)   state_nxt = SEND_R;
            SEND_R:  if (ByteReady) state_nxt = SEND_G;
            SEND_G:  if (ByteReady) state_nxt = SEND_B;
            SEND_B:  if (ByteReady) state_nxt = full_other ? SEND_R : IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Mux selects and display-side flags decoded purely from registered state
    always_comb begin
        ByteValid = (state != IDLE);
        OutSel    = rd_ptr;
        SelR1     = (state == SEND_R) & ~rd_ptr;
        SelG1     = (state == SEND_G) & ~rd_ptr;
        SelB1     = (state == SEND_B) & ~rd_ptr;
        SelR2     = (state == SEND_R) &  rd_ptr;
        SelG2     = (state == SEND_G) &  rd_ptr;
        SelB2     = (state == SEND_B) &  rd_ptr;
        EndOfLine = (state == SEND_B) & (pix_count == LAST_PIX);
    end

endmodule
`default_nettype wire

// File: tb/tb_rgb_buf_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rgb_buf_sequencer
//  Function : Self-checking bench for rgb_buf_sequencer with a queue-based
//             reference model and directed plus randomized stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_buf_sequencer;

    localparam int LP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_valid = 1'b0;
    logic byte_ready = 1'b0;
    logic pix_ready, load1, load2;
    logic sel_r1, sel_g1, sel_b1, sel_r2, sel_g2, sel_b2;
    logic out_sel, byte_valid, end_of_line;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_buf_sequencer #(.LINE_PIXELS(LP), .CW(3)) dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .PixValid  (pix_valid),
        .PixReady  (pix_ready),
        .Load1     (load1),
        .Load2     (load2),
        .SelR1     (sel_r1),
        .SelG1     (sel_g1),
        .SelB1     (sel_b1),
        .SelR2     (sel_r2),
        .SelG2     (sel_g2),
        .SelB2     (sel_b2),
        .OutSel    (out_sel),
        .ByteValid (byte_valid),
        .ByteReady (byte_ready),
        .EndOfLine (end_of_line)
    );

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // q holds the buffer index of every stored pixel, oldest first.
    // ph: 0 = nothing on the display bus, 1/2/3 = sending R/G/B of q[0].
    int q[$];
    int wr = 0;
    int rd = 0;
    int ph = 0;
    int line_pos = 0;
    int sz;
    bit acc, rel;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            wr = 0; rd = 0; ph = 0; line_pos = 0;
        end else begin
            sz  = q.size();
            acc = pix_valid && (sz < 2);
            rel = (ph == 3) && byte_ready;
            if (ph == 0) begin
                if (sz >= 1) ph = 1;
            end else if (byte_ready) begin
                if (ph < 3) ph = ph + 1;
                else        ph = (sz == 2) ? 1 : 0;
            end
            if (rel) begin
                void'(q.pop_front());
                rd = 1 - rd;
                line_pos = (line_pos + 1) % LP;
            end
            if (acc) begin
                q.push_back(wr);
                wr = 1 - wr;
            end
        end
    end

    function automatic logic [11:0] model_out();
        logic       rdy;
        logic [5:0] sel;
        rdy = rst_n && (q.size() < 2);
        sel = '0;
        if (ph != 0) sel[5 - (rd * 3 + ph - 1)] = 1'b1;
        return {rdy, rdy & pix_valid & (wr == 0), rdy & pix_valid & (wr == 1),
                sel, rd[0], ph != 0, (ph == 3) && (line_pos == LP - 1)};
    endfunction

    wire [5:0]  sels    = {sel_r1, sel_g1, sel_b1, sel_r2, sel_g2, sel_b2};
    wire [11:0] dut_out = {pix_ready, load1, load2, sels, out_sel, byte_valid, end_of_line};

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("model_cmp", dut_out, model_out());
        check("sel_onehot", 12'($countones(sels) <= 1), 12'd1);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic pv, input logic br);
        @(posedge clk);
        #1;
        rst_n = r; pix_valid = pv; byte_ready = br;
        @(negedge clk);
    endtask

    int   eol_cnt, b_cnt, acc_cnt;
    logic [7:0] eol_mask;
    logic [7:0] load_seq;
    bit   found;

    initial begin
        // Reset held with upstream valid
        rst_n = 1'b0; pix_valid = 1'b1; byte_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs", dut_out, 12'd0);
            if (i < 2) begin @(posedge clk); #1; end
        end
        drive(1, 0, 1);
        check("ready_after_release", 12'(pix_ready), 12'd1);

        // Single pixel with ByteReady high
        drive(1, 1, 1);
        check("single_load1", {10'd0, load1, load2}, 12'b10);
        drive(1, 0, 1);
        check("single_fsm_entry", {7'd0, sels[5:3], out_sel, byte_valid}, 12'b00000);
        drive(1, 0, 1);
        check("single_R1", {7'd0, sels[5:3], out_sel, byte_valid}, 12'b10001);
        drive(1, 0, 1);
        check("single_G1", {7'd0, sels[5:3], out_sel, byte_valid}, 12'b01001);
        drive(1, 0, 1);
        check("single_B1", {7'd0, sels[5:3], out_sel, byte_valid}, 12'b00101);
        drive(1, 0, 1);
        check("single_idle", {9'd0, pix_ready, |sels, byte_valid}, 12'b100);

        // Backpressure during SEND_G of Buf1
        drive(0, 0, 0);
        drive(1, 1, 1);
        drive(1, 0, 1);
        drive(1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1, i < 2, 0);
            check("bp_hold_G1", {10'd0, sel_g1, byte_valid}, 12'b11);
            if (i == 0) check("bp_second_loads_buf2", {10'd0, load1, load2}, 12'b01);
            if (i == 1) check("bp_third_blocked", 12'(pix_ready), 12'd0);
        end
        for (int i = 0; i < 8; i++) drive(1, 0, 1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++)
            drive(logic'($urandom_range(0, 99) != 0),
                  logic'($urandom_range(0, 99) < 60),
                  logic'($urandom_range(0, 99) < 70));

        // Reset while sending the B byte with both buffers full
        drive(0, 0, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive(1, 1, 1);
            if (ph == 3 && q.size() == 2) found = 1;
        end
        check("midop_reached", 12'(found), 12'd1);
        #1 rst_n = 1'b0;
        drive(0, 1, 1);
        check("midop_reset_outputs", dut_out, 12'd0);
        drive(1, 1, 1);
        check("midop_first_load1", {10'd0, load1, load2}, 12'b10);
        drive(1, 0, 1);
        drive(1, 0, 1);
        check("midop_read_R1", {6'd0, sels}, 12'b100000);

        // Line end: eight pixels streamed from a clean reset
        drive(0, 0, 0);
        eol_cnt = 0; b_cnt = 0; acc_cnt = 0; eol_mask = '0; load_seq = '0;
        for (int i = 0; i < 40; i++) begin
            drive(1, acc_cnt < 8, 1);
            if (load1 | load2) begin
                load_seq[acc_cnt[2:0]] = load2;
                acc_cnt++;
            end
            if (end_of_line) begin
                eol_cnt++;
                eol_mask[b_cnt[2:0]] = 1'b1;
            end
            if (sel_b1 | sel_b2) b_cnt++;
        end
        check("line_accepts", 12'(acc_cnt), 12'd8);
        check("line_load_alternation", {4'd0, load_seq}, 12'b10101010);
        check("line_bytes_b", 12'(b_cnt), 12'd8);
        check("line_eol_count", 12'(eol_cnt), 12'd2);
        check("line_eol_pixels", {4'd0, eol_mask}, 12'b10001000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
